// File: rtl/mem_port_arbiter_if.sv
// Signal bundle shared by the fetch/data requesters, the memory port arbiter and the unified memory.
// Defining MEM_ARB_DBG_PORT_EN adds the debug/loader requester signals.
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_stall;
    logic          f_rvalid;
    logic [DW-1:0] f_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_stall;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

`ifdef MEM_ARB_DBG_PORT_EN
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;

    modport slave (
        input  f_req, f_addr,
        output f_gnt, f_stall, f_rvalid, f_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_stall, d_rvalid, d_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output f_req, f_addr,
        input  f_gnt, f_stall, f_rvalid, f_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_stall, d_rvalid, d_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
`else
    modport slave (
        input  f_req, f_addr,
        output f_gnt, f_stall, f_rvalid, f_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_stall, d_rvalid, d_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output f_req, f_addr,
        input  f_gnt, f_stall, f_rvalid, f_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_stall, d_rvalid, d_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
`endif
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data beats fetch, fetch is forced through after STARVE_LIMIT losses.
// Optional debug/loader port with absolute priority when MEM_ARB_DBG_PORT_EN is defined.
module mem_port_arbiter #(
    parameter int AW           = 8,
    parameter int DW           = 8,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rstn,
    mem_port_arbiter_if.slave bus
);
    localparam int            SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

`ifdef MEM_ARB_DBG_PORT_EN
    typedef enum logic [2:0] {IDLE, RD_F, RD_D, WR_D, RD_G} state_e;
`else
    typedef enum logic [1:0] {IDLE, RD_F, RD_D, WR_D} state_e;
`endif

    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [DW-1:0] f_rdata_q, f_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
`ifdef MEM_ARB_DBG_PORT_EN
    logic [DW-1:0] g_rdata_q, g_rdata_d;
`endif

    logic g_win;
    logic d_win;
    logic f_win;
    logic fetch_forced;

    // Grants are purely combinational so the winner reaches memory in the request cycle.
    always_comb begin
        g_win        = 1'b0;
`ifdef MEM_ARB_DBG_PORT_EN
        g_win        = bus.dbg_req;
`endif
        fetch_forced = bus.f_req && (starve_q == STARVE_MAX);
        d_win        = !g_win && bus.d_req && !fetch_forced;
        f_win        = !g_win && bus.f_req && !d_win;
    end

    assign bus.f_gnt   = f_win;
    assign bus.d_gnt   = d_win;
    assign bus.f_stall = bus.f_req && !f_win;
    assign bus.d_stall = bus.d_req && !d_win;
`ifdef MEM_ARB_DBG_PORT_EN
    assign bus.dbg_gnt = g_win;
`endif

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        if (d_win) begin
            bus.mem_addr  = bus.d_addr;
            bus.mem_we    = bus.d_we;
            bus.mem_wdata = bus.d_wdata;
        end else if (f_win) begin
            bus.mem_addr  = bus.f_addr;
        end
`ifdef MEM_ARB_DBG_PORT_EN
        if (g_win) begin
            bus.mem_addr  = bus.dbg_addr;
            bus.mem_we    = bus.dbg_we;
            bus.mem_wdata = bus.dbg_wdata;
        end
`endif
    end

    // Counts data wins while fetch waits; debug cycles leave it untouched.
    always_comb begin
        starve_d = starve_q;
        if (!g_win) begin
            if (!bus.f_req || f_win) begin
                starve_d = '0;
            end else if (d_win && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    // State records who owns the read issued last cycle; rvalid and rdata routing decode from it.
    always_comb begin
        state_d = IDLE;
        if (d_win) begin
            state_d = bus.d_we ? WR_D : RD_D;
        end else if (f_win) begin
            state_d = RD_F;
        end
`ifdef MEM_ARB_DBG_PORT_EN
        if (g_win) begin
            state_d = bus.dbg_we ? IDLE : RD_G;
        end
`endif

        bus.f_rvalid = (state_q == RD_F);
        bus.d_rvalid = (state_q == RD_D);
        f_rdata_d    = (state_q == RD_F) ? bus.mem_rdata : f_rdata_q;
        d_rdata_d    = (state_q == RD_D) ? bus.mem_rdata : d_rdata_q;
        bus.f_rdata  = f_rdata_d;
        bus.d_rdata  = d_rdata_d;
`ifdef MEM_ARB_DBG_PORT_EN
        bus.dbg_rvalid = (state_q == RD_G);
        g_rdata_d      = (state_q == RD_G) ? bus.mem_rdata : g_rdata_q;
        bus.dbg_rdata  = g_rdata_d;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef MEM_ARB_DBG_PORT_EN
            g_rdata_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_DBG_PORT_EN
            g_rdata_q <= g_rdata_d;
`endif
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus random fetch/data traffic.
// Define MEM_ARB_DBG_PORT_EN to also exercise the debug/loader port.
module tb_mem_port_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int SL = 3;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    int         cyc  = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    exp_t       fq[$];
    exp_t       dq[$];
`ifdef MEM_ARB_DBG_PORT_EN
    exp_t       gq[$];
`endif
    logic [7:0] ref_mem [256];
    logic [7:0] tb_mem [256];
    bit         loaded = 1'b0;
    int         data_wins = 0;
    logic       dut_fg;
    logic       dut_dg;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // Unified memory: registered read, write-first.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= init_byte(i);
            loaded <= 1'b1;
        end else if (bus.mem_we) begin
            tb_mem[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= bus.mem_we ? bus.mem_wdata : tb_mem[bus.mem_addr];
    end

    assert property (@(posedge clk) disable iff (!rstn) (bus.f_req && !bus.f_gnt) |=> bus.f_req)
        else $error("protocol: f_req dropped while stalled");
    assert property (@(posedge clk) disable iff (!rstn) (bus.d_req && !bus.d_gnt) |=> bus.d_req)
        else $error("protocol: d_req dropped while stalled");

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One bus cycle: drive requests, predict the winner from the priority rules, update the reference.
    task automatic step(input logic fr, input logic [7:0] fa, input logic dr, input logic dwe,
                        input logic [7:0] da, input logic [7:0] dwd, output bit fg, output bit dg);
        bit         gg;
        bit         force_f;
        logic       exp_we;
        logic [7:0] exp_addr;
        logic [7:0] exp_wd;
        @(negedge clk);
        bus.f_req   = fr;
        bus.f_addr  = fa;
        bus.d_req   = dr;
        bus.d_we    = dwe;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
        #1;
        gg = 1'b0;
`ifdef MEM_ARB_DBG_PORT_EN
        gg = bus.dbg_req;
`endif
        force_f = fr && (data_wins >= SL);
        dg      = !gg && dr && !force_f;
        fg      = !gg && fr && !dg;
        dut_fg  = bus.f_gnt;
        dut_dg  = bus.d_gnt;
        check("f_gnt", bus.f_gnt, fg);
        check("d_gnt", bus.d_gnt, dg);
        check("f_stall", bus.f_stall, fr && !fg);
        check("d_stall", bus.d_stall, dr && !dg);

        exp_we   = 1'b0;
        exp_addr = 8'h00;
        exp_wd   = 8'h00;
        if (dg) begin
            exp_we   = dwe;
            exp_addr = da;
            exp_wd   = dwd;
        end else if (fg) begin
            exp_addr = fa;
        end
`ifdef MEM_ARB_DBG_PORT_EN
        check("dbg_gnt", bus.dbg_gnt, gg);
        if (gg) begin
            exp_we   = bus.dbg_we;
            exp_addr = bus.dbg_addr;
            exp_wd   = bus.dbg_wdata;
            if (bus.dbg_we) ref_mem[bus.dbg_addr] = bus.dbg_wdata;
            else gq.push_back('{ref_mem[bus.dbg_addr], cyc + 1});
        end
`endif
        check("mem_we", bus.mem_we, exp_we);
        check("mem_addr", bus.mem_addr, exp_addr);
        if (exp_we) check("mem_wdata", bus.mem_wdata, exp_wd);

        if (dg) begin
            if (dwe) ref_mem[da] = dwd;
            else dq.push_back('{ref_mem[da], cyc + 1});
        end else if (fg) begin
            fq.push_back('{ref_mem[fa], cyc + 1});
        end

        if (!rstn) data_wins = 0;
        else if (!gg) data_wins = (dg && fr) ? data_wins + 1 : 0;
    endtask

    initial begin : monitor
        exp_t       e;
        bit         exp_v;
        logic [7:0] last_f = 8'h00;
        logic [7:0] last_d = 8'h00;
`ifdef MEM_ARB_DBG_PORT_EN
        logic [7:0] last_g = 8'h00;
`endif
        forever begin
            @(negedge clk);
            #2;
            if (!rstn) begin
                check("rst_f_rvalid", bus.f_rvalid, 1'b0);
                check("rst_d_rvalid", bus.d_rvalid, 1'b0);
                check("rst_f_rdata", bus.f_rdata, 8'h00);
                check("rst_d_rdata", bus.d_rdata, 8'h00);
                fq.delete();
                dq.delete();
                last_f = 8'h00;
                last_d = 8'h00;
`ifdef MEM_ARB_DBG_PORT_EN
                check("rst_dbg_rvalid", bus.dbg_rvalid, 1'b0);
                gq.delete();
                last_g = 8'h00;
`endif
            end else begin
                exp_v = (fq.size() != 0) && (fq[0].due == cyc);
                check("f_rvalid", bus.f_rvalid, exp_v);
                if (exp_v) begin
                    e = fq.pop_front();
                    last_f = e.data;
                    check("f_rdata", bus.f_rdata, e.data);
                end else begin
                    check("f_rdata_hold", bus.f_rdata, last_f);
                end

                exp_v = (dq.size() != 0) && (dq[0].due == cyc);
                check("d_rvalid", bus.d_rvalid, exp_v);
                if (exp_v) begin
                    e = dq.pop_front();
                    last_d = e.data;
                    check("d_rdata", bus.d_rdata, e.data);
                end else begin
                    check("d_rdata_hold", bus.d_rdata, last_d);
                end
`ifdef MEM_ARB_DBG_PORT_EN
                exp_v = (gq.size() != 0) && (gq[0].due == cyc);
                check("dbg_rvalid", bus.dbg_rvalid, exp_v);
                if (exp_v) begin
                    e = gq.pop_front();
                    last_g = e.data;
                    check("dbg_rdata", bus.dbg_rdata, e.data);
                end else begin
                    check("dbg_rdata_hold", bus.dbg_rdata, last_g);
                end
`endif
            end
        end
    end

    initial begin : stimulus
        bit         fg;
        bit         dg;
        bit         fp;
        bit         dp;
        logic       rwe;
        logic [7:0] rfa;
        logic [7:0] rda;
        logic [7:0] rwd;
        logic [7:0] sfa;
        logic [7:0] sda;
        logic [1:0] pat [7];

        bus.f_req   = 1'b0;
        bus.f_addr  = 8'h00;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 8'h00;
        bus.d_wdata = 8'h00;
`ifdef MEM_ARB_DBG_PORT_EN
        bus.dbg_req   = 1'b0;
        bus.dbg_we    = 1'b0;
        bus.dbg_addr  = 8'h00;
        bus.dbg_wdata = 8'h00;
`endif
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);

        // Reset with no requests, then release and idle.
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, fg, dg);
        rstn = 1'b1;
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, fg, dg);

        // Fetch stream 10..13.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(10 + i), 1'b0, 1'b0, 8'h00, 8'h00, fg, dg);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, fg, dg);

        // Same-cycle conflict: data first, fetch the cycle after.
        step(1'b1, 8'h30, 1'b1, 1'b0, 8'h20, 8'h00, fg, dg);
        check("conflict_first", {dut_fg, dut_dg}, 2'b01);
        step(1'b1, 8'h30, 1'b0, 1'b0, 8'h00, 8'h00, fg, dg);
        check("conflict_second", {dut_fg, dut_dg}, 2'b10);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, fg, dg);

        // Starvation: d_req for 6 cycles, f_req throughout -> D,D,D,F,D,D,F.
        pat = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
        sfa = 8'h50;
        sda = 8'h60;
        for (int c = 0; c < 7; c++) begin
            step(1'b1, sfa, (c < 6), 1'b0, sda, 8'h00, fg, dg);
            check("starve_seq", {dut_fg, dut_dg}, pat[c]);
            if (fg) sfa = sfa + 8'h01;
            if (dg) sda = sda + 8'h01;
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, fg, dg);

        // Stack push/pop at the top address.
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hAA, fg, dg);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, fg, dg);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, fg, dg);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, fg, dg);

        // Reset landing between a data read grant and its rvalid.
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h21, 8'h00, fg, dg);
        check("midrd_gnt", dut_dg, 1'b1);
        #2 rstn = 1'b0;
        @(negedge clk);
        bus.d_req = 1'b0;
        data_wins = 0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, fg, dg);

`ifdef MEM_ARB_DBG_PORT_EN
        // Debug port pre-empts both requesters until it lets go.
        bus.dbg_req  = 1'b1;
        bus.dbg_we   = 1'b0;
        bus.dbg_addr = 8'h05;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h70, 1'b1, 1'b0, 8'h22, 8'h00, fg, dg);
            check("dbg_only", {dut_fg, dut_dg}, 2'b00);
        end
        bus.dbg_we    = 1'b1;
        bus.dbg_addr  = 8'h22;
        bus.dbg_wdata = 8'h5A;
        step(1'b1, 8'h70, 1'b1, 1'b0, 8'h22, 8'h00, fg, dg);
        bus.dbg_req = 1'b0;
        bus.dbg_we  = 1'b0;
        step(1'b1, 8'h70, 1'b1, 1'b0, 8'h22, 8'h00, fg, dg);
        check("dbg_release_d", {dut_fg, dut_dg}, 2'b01);
        step(1'b1, 8'h70, 1'b0, 1'b0, 8'h00, 8'h00, fg, dg);
        check("dbg_release_f", {dut_fg, dut_dg}, 2'b10);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, fg, dg);
`endif

        // Random traffic; requests stay up (address/data stable) until the reference grants them.
        fp  = 1'b0;
        dp  = 1'b0;
        rfa = 8'hF0;
        rda = 8'h00;
        rwd = 8'h00;
        rwe = 1'b0;
        for (int c = 0; c < 620; c++) begin
            if (c < 600) begin
                if (!fp && ($urandom_range(0, 3) != 0)) begin
                    fp  = 1'b1;
                    rfa = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : rfa + 8'h01;
                end
                if (!dp && ($urandom_range(0, 2) != 0)) begin
                    dp  = 1'b1;
                    rwe = 1'($urandom_range(0, 1));
                    rda = ($urandom_range(0, 1) == 0) ? 8'(8'hF8 + 8'($urandom_range(0, 7)))
                                                      : 8'($urandom_range(0, 15));
                    rwd = 8'($urandom_range(0, 255));
                end
            end
            step(fp, rfa, dp, rwe, rda, rwd, fg, dg);
            if (fg) fp = 1'b0;
            if (dg) dp = 1'b0;
        end
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, fg, dg);
        check("fq_drained", fq.size(), 0);
        check("dq_drained", dq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
